smachine_switch_port: RTL and testbench
=======================================

Name: smachine_switch_port

Overview:
- Input-side peripheral for the S-Machine CPU: the reader/consumer end of the board switch interface (switch0, switch1).
- Synchronises and debounces raw switch levels, and captures sticky rising-edge flags.
- The CPU reads levels and flags through a single-request, fixed-latency read port.
- Sits between the top-level switch pins and the CPU I/O read path; drives an interrupt line when any flag is pending.

Parameters:
- NUM_SW, 2: number of switch inputs, 1..8.
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronised level must differ from the stable level before the stable level updates. Must be at least 1.
- CNT_W, 3: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  CPU run enable; gates debounce and flag capture.
- switch_in  input  NUM_SW  raw asynchronous switch levels; bit 0 is switch0.
- rd_req  input  1  one-cycle read strobe.
- rd_addr  input  2  read select: 0 = stable levels, 1 = rise flags, 2 = fall flags, 3 = status.
- rd_data  output  8  read result, zero-extended.
- rd_valid  output  1  one-cycle pulse; rd_data is valid while it is high.
- irq  output  1  high while any flag is set.

Behaviour:
- Clocking and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: asserting reset immediately clears all state, including mid-debounce counts and a read in flight.
  - Outputs: rd_data=0, rd_valid=0, irq=0.
  - Internal: sync stages, stable levels, counters and all flags = 0.
- Synchroniser: each bit passes through two flops (sync1, sync2). The synchroniser runs regardless of enable.
- Debounce, per bit, when enable=1:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - sync2 != stable otherwise: counter <= counter+1.
- Debounce latency: with edge 1 being the first edge that samples the new switch_in value, stable changes at edge DEBOUNCE_CYCLES+2 (edge 6 at default).
- Glitch rejection: a glitch that returns to the old level before then resets the count; stable does not change.
- enable=0:
  - Counters are held at 0 and stable is frozen.
  - No flags are set; existing flags are retained.
  - Reads are still serviced.
- Edge capture: a 0->1 transition of stable sets rise_flag[i]. Flags are sticky until read.
- Read protocol:
  - rd_req sampled high at edge n gives rd_valid=1 and rd_data registered at edge n+1, for exactly one cycle.
  - Back-to-back requests are allowed; each produces exactly one response, one cycle later.
  - rd_req is not qualified by enable.
- Read data by rd_addr:
  - 0: stable levels.
  - 1: rise flags.
  - 2: fall flags.
  - 3: {6'b0, irq, enable}.
  - Bits [7:NUM_SW] read 0.
- Clear-on-read: a read of address 1 (or 2) clears exactly the flags returned, at the same edge that registers rd_data.
- Simultaneous set and clear: if a new edge for bit i occurs on the clearing edge, flag i ends up 1. The set wins, so the new event is not lost.
- irq: registered OR of all rise flags (and fall flags when the feature is compiled in). It updates one cycle after the flag change.

Optional Feature:
- Macro: SWITCH_FALL_EDGE_EN.
- Defined:
  - A 1->0 transition of stable sets fall_flag[i], with the same sticky and clear-on-read rules as rise flags.
  - Address 2 returns fall flags.
  - Fall flags contribute to irq.
- Undefined:
  - No fall-flag storage exists.
  - Address 2 reads 0 and still produces rd_valid.
  - irq depends on rise flags only.

Test Plan:
- Reset state: reset=1 for 3 cycles, then release with switch_in=2'b11 and enable=0, and hold 20 cycles. Required: rd_data=0, rd_valid=0, irq=0 throughout. A read of address 0 returns 8'h00.
- Debounce latency: enable=1, raise switch0. Required: stable bit 0 = 1 exactly at edge 6 after the change. rise_flag[0]=1 and irq=1 one edge later. A read of address 1 returns 8'h01, then a second read returns 8'h00 and irq falls.
- Glitch rejection: pulse switch1 high for 3 cycles with DEBOUNCE_CYCLES=4. Required: address 0 reads 8'h00 and no flag is set. A 5-cycle pulse sets rise_flag[1] (address 1 reads 8'h02).
- Set/clear collision: time a read of address 1 so its clearing edge coincides with switch1's stable 0->1 edge, while rise_flag[0] is pending. Required: the response is 8'h01, and a following read returns 8'h02.
- Mid-operation reset: assert reset during an active debounce count and with rd_req high. Required: rd_valid stays 0 and stable is 0. After release, a fresh full DEBOUNCE_CYCLES+2 edges are needed before stable updates.
- Fall edges:
  - With SWITCH_FALL_EDGE_EN defined: drop switch0 after it is stable high; a read of address 2 returns 8'h01 and irq is set.
  - Without the macro: the same stimulus gives an address-2 read of 8'h00 and irq=0.

Source files
------------

// File: rtl/smachine_switch_port.sv
// smachine_switch_port: switch input peripheral for the S-Machine CPU.
// Two-flop synchroniser, per-bit debounce, sticky rise (and optionally fall)
// flags with clear-on-read, and a one-cycle-latency CPU read port.
// Optional feature macro: SWITCH_FALL_EDGE_EN (fall-edge flags on address 2).
module smachine_switch_port #(
  parameter int NUM_SW          = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_SW-1:0] switch_in,
  input  logic              rd_req,
  input  logic [1:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] sync1_q, sync1_d;
  logic [NUM_SW-1:0] sync2_q, sync2_d;
  logic [NUM_SW-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q [NUM_SW];
  logic [CNT_W-1:0]  cnt_d [NUM_SW];
  logic [NUM_SW-1:0] rise_q, rise_d;
`ifdef SWITCH_FALL_EDGE_EN
  logic [NUM_SW-1:0] fall_q, fall_d;
`endif
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              irq_q, irq_d;

  // Zero-extend a switch-wide vector onto the 8-bit read bus.
  function automatic logic [7:0] zext(input logic [NUM_SW-1:0] v);
    logic [7:0] r;
    r = '0;
    r[NUM_SW-1:0] = v;
    return r;
  endfunction

  // Synchronise, debounce, capture edges, serve reads and form irq.
  always_comb begin
    logic [NUM_SW-1:0] rise_set;
    logic [NUM_SW-1:0] rise_clr;
`ifdef SWITCH_FALL_EDGE_EN
    logic [NUM_SW-1:0] fall_set;
    logic [NUM_SW-1:0] fall_clr;
`endif
    sync1_d  = switch_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      // Counting only while disabled is suppressed, so stable freezes too.
      if (enable && (sync2_q[i] != stable_q[i])) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    // Edges are taken from the debounce update so a flag sets on the same
    // edge stable changes; a set on a clearing edge wins over the clear.
    rise_set = stable_d & ~stable_q;
    rise_clr = (rd_req && (rd_addr == 2'd1)) ? rise_q : '0;
    rise_d   = (rise_q & ~rise_clr) | rise_set;
`ifdef SWITCH_FALL_EDGE_EN
    fall_set = ~stable_d & stable_q;
    fall_clr = (rd_req && (rd_addr == 2'd2)) ? fall_q : '0;
    fall_d   = (fall_q & ~fall_clr) | fall_set;
    irq_d    = (|rise_q) | (|fall_q);
`else
    irq_d    = |rise_q;
`endif

    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    if (rd_req) begin
      case (rd_addr)
        2'd0:    rd_data_d = zext(stable_q);
        2'd1:    rd_data_d = zext(rise_q);
`ifdef SWITCH_FALL_EDGE_EN
        2'd2:    rd_data_d = zext(fall_q);
`else
        2'd2:    rd_data_d = 8'h00;
`endif
        default: rd_data_d = {6'b0, irq_q, enable};
      endcase
    end
  end

  // State register; reset clears everything, including a read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
      rise_q     <= '0;
`ifdef SWITCH_FALL_EDGE_EN
      fall_q     <= '0;
`endif
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= cnt_d[i];
      rise_q     <= rise_d;
`ifdef SWITCH_FALL_EDGE_EN
      fall_q     <= fall_d;
`endif
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_smachine_switch_port.sv
// Self-checking bench for smachine_switch_port: read responses are checked
// through a scoreboard queue, plus a table of register/enable vectors and
// hand-written multi-cycle sequences for debounce, glitch, collision, reset.
module tb_smachine_switch_port;

`ifdef SWITCH_FALL_EDGE_EN
  localparam logic FALL_EN = 1'b1;
`else
  localparam logic FALL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] switch_in = 2'b00;
  logic       rd_req = 1'b0;
  logic [1:0] rd_addr = 2'd0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       irq;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic       en;
    logic [1:0] sw;
    int         wait_cyc;
    logic [1:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [9];

  smachine_switch_port #(.NUM_SW(2), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .switch_in(switch_in),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock; afterwards the response to a request sampled at that edge is
  // popped from the scoreboard and compared.
  task automatic step();
    logic req_s;
    req_s = rd_req && !reset;
    @(posedge clk);
    #1;
    if (req_s) begin
      check("rd_valid_resp", {7'b0, rd_valid}, 8'h01);
      if (sb.size() == 0) begin
        check("sb_underflow", 8'h01, 8'h00);
      end else begin
        check("rd_data", rd_data, sb.pop_front());
      end
    end else begin
      check("rd_valid_idle", {7'b0, rd_valid}, 8'h00);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [1:0] addr, input logic [7:0] exp);
    rd_req  = 1'b1;
    rd_addr = addr;
    sb.push_back(exp);
    step();
    rd_req  = 1'b0;
  endtask

  // Back-to-back address-0 reads across a switch0 0->1 change: a read sampled
  // at edge k returns stable after edge k-1, so bit 0 appears from k=7 when
  // stable flips at edge 6; irq follows the flag by one edge (edge 7).
  task automatic run_latency();
    for (int k = 1; k <= 8; k++) begin
      rd_req  = 1'b1;
      rd_addr = 2'd0;
      sb.push_back((k >= 7) ? 8'h01 : 8'h00);
      step();
      check("irq_latency", {7'b0, irq}, (k >= 7) ? 8'h01 : 8'h00);
    end
    rd_req = 1'b0;
  endtask

  initial begin
    vecs[0] = '{en: 1'b1, sw: 2'b00, wait_cyc: 2,  addr: 2'd3, exp: 8'h01};
    vecs[1] = '{en: 1'b0, sw: 2'b11, wait_cyc: 10, addr: 2'd0, exp: 8'h00};
    vecs[2] = '{en: 1'b0, sw: 2'b11, wait_cyc: 0,  addr: 2'd1, exp: 8'h00};
    vecs[3] = '{en: 1'b0, sw: 2'b11, wait_cyc: 0,  addr: 2'd3, exp: 8'h00};
    vecs[4] = '{en: 1'b1, sw: 2'b11, wait_cyc: 8,  addr: 2'd0, exp: 8'h03};
    vecs[5] = '{en: 1'b1, sw: 2'b11, wait_cyc: 1,  addr: 2'd3, exp: 8'h03};
    vecs[6] = '{en: 1'b0, sw: 2'b11, wait_cyc: 0,  addr: 2'd1, exp: 8'h03};
    vecs[7] = '{en: 1'b0, sw: 2'b00, wait_cyc: 10, addr: 2'd0, exp: 8'h03};
    vecs[8] = '{en: 1'b0, sw: 2'b00, wait_cyc: 0,  addr: 2'd3, exp: 8'h00};

    // Reset state, then released with switches high while disabled.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_rd_data", rd_data, 8'h00);
      check("reset_irq", {7'b0, irq}, 8'h00);
    end
    reset = 1'b0;
    switch_in = 2'b11;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_rd_data", rd_data, 8'h00);
      check("idle_irq", {7'b0, irq}, 8'h00);
    end
    rd(2'd0, 8'h00);

    // Debounce latency and clear-on-read of the rise flag.
    switch_in = 2'b00;
    steps(4);
    enable = 1'b1;
    steps(2);
    switch_in = 2'b01;
    run_latency();
    rd(2'd1, 8'h01);
    rd(2'd1, 8'h00);
    check("irq_after_clear", {7'b0, irq}, 8'h00);

    // Glitch rejection: 3-cycle pulse ignored, 5-cycle pulse accepted.
    switch_in = 2'b11;
    steps(3);
    switch_in = 2'b01;
    steps(6);
    rd(2'd0, 8'h01);
    rd(2'd1, 8'h00);
    switch_in = 2'b11;
    steps(5);
    switch_in = 2'b01;
    steps(8);
    check("irq_pulse5", {7'b0, irq}, 8'h01);
    rd(2'd0, 8'h01);
    rd(2'd1, 8'h02);
    rd(2'd2, FALL_EN ? 8'h02 : 8'h00);

    // Set/clear collision: read of address 1 clears on switch1's rising edge.
    switch_in = 2'b00;
    steps(10);
    switch_in = 2'b01;
    steps(10);
    switch_in = 2'b11;
    steps(5);
    rd(2'd1, 8'h01);
    rd(2'd1, 8'h02);
    step();
    check("irq_after_collision", {7'b0, irq}, {7'b0, FALL_EN});

    // Mid-operation reset during a count and with a read requested.
    switch_in = 2'b00;
    steps(10);
    switch_in = 2'b01;
    steps(4);
    rd_req  = 1'b1;
    rd_addr = 2'd0;
    reset   = 1'b1;
    #1;
    check("midrst_rd_valid", {7'b0, rd_valid}, 8'h00);
    check("midrst_rd_data", rd_data, 8'h00);
    check("midrst_irq", {7'b0, irq}, 8'h00);
    steps(2);
    reset  = 1'b0;
    rd_req = 1'b0;
    run_latency();

    // Fall edge on switch0.
    rd(2'd1, 8'h01);
    switch_in = 2'b00;
    steps(10);
    check("fall_irq", {7'b0, irq}, {7'b0, FALL_EN});
    rd(2'd2, FALL_EN ? 8'h01 : 8'h00);

    // Register and enable-gating vectors.
    for (int v = 0; v < 9; v++) begin
      enable    = vecs[v].en;
      switch_in = vecs[v].sw;
      steps(vecs[v].wait_cyc);
      rd(vecs[v].addr, vecs[v].exp);
    end

    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
